// File: rtl/spi_master_multi.sv
// -----------------------------------------------------------------------------
// spi_master_multi
//   Parametrised SPI master. Serialises a DATA_W-bit word MSB first to one of
//   N_SLAVES chip selects and returns the word captured on miso. It supports
//   all four SPI modes (CPOL/CPHA) and has a programmable sclk divider
//   (CLK_DIV clk cycles per sclk half-period).
//
//   Optional feature macro: SPI_MASTER_LOOPBACK_EN
//     When this macro is defined, the module has an extra `loopback` input.
//     If loopback=1 at accept, the receive shift register samples the
//     internal mosi instead of miso, and every chip select stays high for
//     that transfer.
//
// Ports
//   clk       in   1         system clock, everything on posedge
//   rst_n     in   1         asynchronous active-low reset
//   tx_data   in   DATA_W    word to send, MSB first
//   tx_slave  in   SEL_W     target slave index (>= N_SLAVES: no cs asserted)
//   tx_valid  in   1         request valid
//   tx_ready  out  1         master idle
//   rx_data   out  DATA_W    received word, held until the next rx_valid
//   rx_valid  out  1         one-cycle pulse, rx_data updated
//   sclk      out  1         SPI clock (flop driven)
//   mosi      out  1         serial data out (flop driven)
//   miso      in   1         serial data in
//   cs_n      out  N_SLAVES  active-low chip selects (flop driven)
//   loopback  in   1         only with SPI_MASTER_LOOPBACK_EN
//
// Request handshake: a request is accepted on a clk edge where
//   tx_valid & tx_ready. tx_data, tx_slave (and loopback) are latched at that
//   edge, and tx_ready stays low until the transfer has completed. Inputs are
//   ignored while tx_ready is low.
// -----------------------------------------------------------------------------
module spi_master_multi #(
    parameter int  DATA_W   = 8,
    parameter int  N_SLAVES = 2,
    parameter int  CLK_DIV  = 2,
    parameter bit  CPOL     = 1'b0,
    parameter bit  CPHA     = 1'b0,
    localparam int SEL_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic [SEL_W-1:0]    tx_slave,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [DATA_W-1:0]   rx_data,
    output logic                rx_valid,
    output logic                sclk,
    output logic                mosi,
    input  logic                miso,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                loopback,
`endif
    output logic [N_SLAVES-1:0] cs_n
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    // Index of the final sclk edge, and the count reached after it.
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
    localparam logic [EDGE_W-1:0] EDGE_END  = EDGE_W'(2 * DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [N_SLAVES-1:0] cs_n_q, cs_n_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                lb_q, lb_d;

    logic                div_done;
    logic                do_edge;
    logic [EDGE_W-1:0]   edge_idx;
    logic                sample_edge;
    logic                shift_edge;
    logic                miso_eff;
    logic                lb_req;
    logic [N_SLAVES-1:0] cs_sel;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign lb_req = loopback;
`else
    assign lb_req = 1'b0;
`endif

    // In loopback, the word just driven on mosi is what gets captured.
    assign miso_eff = lb_q ? mosi_q : miso;

    // Decode the requested slave. An index beyond N_SLAVES leaves all high.
    always_comb begin
        cs_sel = '1;
        for (int i = 0; i < N_SLAVES; i++) begin
            cs_sel[i] = (tx_slave != SEL_W'(i));
        end
    end

    // Even edge indices are leading edges. CPHA=0 samples on leading edges,
    // CPHA=1 samples on trailing edges. With CPHA=0 the MSB is already on mosi
    // from accept, so the final trailing edge has nothing left to present.
    assign sample_edge = (edge_idx[0] == CPHA);
    assign shift_edge  = CPHA ? ~edge_idx[0]
                              : (edge_idx[0] && (edge_idx != EDGE_LAST));

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        edge_d     = edge_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        lb_d       = lb_q;
        div_done   = (div_q == DIV_LAST);
        do_edge    = 1'b0;
        edge_idx   = edge_q;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d = SETUP;
                    div_d   = '0;
                    edge_d  = '0;
                    lb_d    = lb_req;
                    cs_n_d  = lb_req ? '1 : cs_sel;
                    if (CPHA) begin
                        tx_sr_d = tx_data;
                    end else begin
                        mosi_d  = tx_data[DATA_W-1];
                        tx_sr_d = {tx_data[DATA_W-2:0], 1'b0};
                    end
                end
            end
            SETUP: begin
                if (div_done) begin
                    div_d    = '0;
                    do_edge  = 1'b1;
                    edge_idx = '0;
                    edge_d   = EDGE_W'(1);
                    state_d  = SHIFT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_done) begin
                    div_d = '0;
                    // One idle half-period follows the last edge before HOLD.
                    if (edge_q == EDGE_END) begin
                        edge_d  = '0;
                        state_d = HOLD;
                    end else begin
                        do_edge = 1'b1;
                        edge_d  = edge_q + EDGE_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HOLD: begin
                if (div_done) begin
                    div_d      = '0;
                    state_d    = IDLE;
                    cs_n_d     = '1;
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_edge) begin
            sclk_d = ~sclk_q;
            if (sample_edge) begin
                rx_sr_d = {rx_sr_q[DATA_W-2:0], miso_eff};
            end
            if (shift_edge) begin
                mosi_d  = tx_sr_q[DATA_W-1];
                tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            edge_q     <= '0;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            lb_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            lb_q       <= lb_d;
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// -----------------------------------------------------------------------------
// tb_spi_master_multi
//   Directed bench for spi_master_multi. There are three instances:
//     dut0: DATA_W=8, N_SLAVES=2, CLK_DIV=2, mode 0, with a slave returning 0x3C
//     dut1: DATA_W=8, N_SLAVES=2, CLK_DIV=2, mode 3, with a slave returning 0x3C
//     dut2: DATA_W=8, N_SLAVES=3, CLK_DIV=2, mode 0, with miso tied high
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master_multi;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic [1:0] tx_slave;
    logic [2:0] tx_valid;
    logic [2:0] tx_ready;
    logic [2:0] rx_valid;
    logic [2:0] sclk;
    logic [2:0] mosi;
    logic [2:0] miso;
    logic [7:0] rx_data0, rx_data1, rx_data2;
    logic [1:0] cs_n0, cs_n1;
    logic [2:0] cs_n2;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic       loopback;
`endif

    int checks   = 0;
    int failures = 0;

    // Results of the most recent run_xfer call.
    int         rs_lat;
    int         rs_rises;
    logic [7:0] rs_mosi;
    logic [7:0] rs_rx;
    logic [2:0] rs_cs;
    logic       rs_cs_any;
    logic       rs_cs_bad;
    logic       rs_mosi_bad;
    logic       rs_timeout;
    logic       rs_pulse_ok;
    logic       rs_ready_before;
    logic       rs_sclk_end;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    spi_master_multi #(.DATA_W(8), .N_SLAVES(2), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_slave(tx_slave[0:0]),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .rx_data(rx_data0),
        .rx_valid(rx_valid[0]), .sclk(sclk[0]), .mosi(mosi[0]), .miso(miso[0]),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(loopback),
`endif
        .cs_n(cs_n0)
    );

    spi_master_multi #(.DATA_W(8), .N_SLAVES(2), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_slave(tx_slave[0:0]),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .rx_data(rx_data1),
        .rx_valid(rx_valid[1]), .sclk(sclk[1]), .mosi(mosi[1]), .miso(miso[1]),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .cs_n(cs_n1)
    );

    spi_master_multi #(.DATA_W(8), .N_SLAVES(3), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_slave(tx_slave),
        .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .rx_data(rx_data2),
        .rx_valid(rx_valid[2]), .sclk(sclk[2]), .mosi(mosi[2]), .miso(miso[2]),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .cs_n(cs_n2)
    );

    // ---------------- slave models (respond with 0x3C) ----------------
    // Mode 0 slave: reloads while deselected, and moves to the next bit one
    // clk after each falling sclk edge.
    logic [7:0] s0_sr;
    logic       s0_prev;
    always @(posedge clk) begin
        s0_prev <= sclk[0];
        if (&cs_n0)                  s0_sr <= 8'h3C;
        else if (s0_prev && !sclk[0]) s0_sr <= {s0_sr[6:0], 1'b0};
    end
    assign miso[0] = s0_sr[7];

    // Mode 3 slave: the MSB appears after the first (leading, falling) edge.
    logic [8:0] s1_sr;
    logic       s1_prev;
    always @(posedge clk) begin
        s1_prev <= sclk[1];
        if (&cs_n1)                  s1_sr <= {1'b0, 8'h3C};
        else if (s1_prev && !sclk[1]) s1_sr <= {s1_sr[7:0], 1'b0};
    end
    assign miso[1] = s1_sr[8];

    assign miso[2] = 1'b1;

    // ---------------- helpers ----------------
    function automatic logic [2:0] get_cs(input int d);
        case (d)
            0:       get_cs = {1'b1, cs_n0};
            1:       get_cs = {1'b1, cs_n1};
            default: get_cs = cs_n2;
        endcase
    endfunction

    function automatic logic [7:0] get_rx(input int d);
        case (d)
            0:       get_rx = rx_data0;
            1:       get_rx = rx_data1;
            default: get_rx = rx_data2;
        endcase
    endfunction

    // Issue one request on DUT d and observe it at every falling clk edge
    // until rx_valid is seen (bounded).
    task automatic run_xfer(input int d, input logic [7:0] data, input logic [1:0] slave);
        int         n;
        logic       ps, pm, s, m;
        logic [2:0] c;
        @(negedge clk);
        tx_data  = data;
        tx_slave = slave;
        tx_valid[d] = 1'b1;
        rs_ready_before = tx_ready[d];
        @(negedge clk);
        tx_valid[d] = 1'b0;
        n = 0;
        rs_rises = 0; rs_mosi = '0; rs_cs = 3'b111; rs_cs_any = 1'b0;
        rs_cs_bad = 1'b0; rs_mosi_bad = 1'b0;
        ps = sclk[d];
        pm = mosi[d];
        c  = get_cs(d);
        if (c != 3'b111) begin rs_cs = c; rs_cs_any = 1'b1; end
        while (!rx_valid[d] && n < 100) begin
            @(negedge clk);
            n++;
            s = sclk[d];
            m = mosi[d];
            if (!ps && s) begin
                rs_mosi = {rs_mosi[6:0], m};
                rs_rises++;
            end
            if ((m != pm) && !(ps && !s)) rs_mosi_bad = 1'b1;
            c = get_cs(d);
            if (c != 3'b111) begin
                if (!rs_cs_any) rs_cs = c;
                else if (c != rs_cs) rs_cs_bad = 1'b1;
                rs_cs_any = 1'b1;
            end
            ps = s;
            pm = m;
        end
        rs_timeout  = !rx_valid[d];
        rs_lat      = n;
        rs_rx       = get_rx(d);
        rs_sclk_end = sclk[d];
        @(negedge clk);
        rs_pulse_ok = !rx_valid[d] && tx_ready[d];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [2:0] cpol_exp;
        cpol_exp = 3'b010;
        rst_n = 1'b0;
        tx_valid = '0;
        tx_data = '0;
        tx_slave = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++; if (tx_ready[d] !== 1'b1) begin failures++; $display("FAIL reset_tx_ready[%0d] got=%b exp=1", d, tx_ready[d]); end
            checks++; if (rx_valid[d] !== 1'b0) begin failures++; $display("FAIL reset_rx_valid[%0d] got=%b exp=0", d, rx_valid[d]); end
            checks++; if (get_rx(d) !== 8'h00) begin failures++; $display("FAIL reset_rx_data[%0d] got=%h exp=00", d, get_rx(d)); end
            checks++; if (sclk[d] !== cpol_exp[d]) begin failures++; $display("FAIL reset_sclk[%0d] got=%b exp=%b", d, sclk[d], cpol_exp[d]); end
            checks++; if (mosi[d] !== 1'b0) begin failures++; $display("FAIL reset_mosi[%0d] got=%b exp=0", d, mosi[d]); end
            checks++; if (get_cs(d) !== 3'b111) begin failures++; $display("FAIL reset_cs_n[%0d] got=%b exp=111", d, get_cs(d)); end
        end
    endtask

    task automatic test_basic;
        run_xfer(0, 8'hA5, 2'd0);
        checks++; if (rs_ready_before !== 1'b1) begin failures++; $display("FAIL t1_ready got=%b exp=1", rs_ready_before); end
        checks++; if (rs_timeout !== 1'b0) begin failures++; $display("FAIL t1_timeout got=%b exp=0", rs_timeout); end
        checks++; if (rs_lat !== 36) begin failures++; $display("FAIL t1_latency got=%0d exp=36", rs_lat); end
        checks++; if (rs_mosi !== 8'hA5) begin failures++; $display("FAIL t1_mosi_bits got=%h exp=a5", rs_mosi); end
        checks++; if (rs_rises !== 8) begin failures++; $display("FAIL t1_sclk_pulses got=%0d exp=8", rs_rises); end
        checks++; if (rs_cs !== 3'b110 || rs_cs_bad) begin failures++; $display("FAIL t1_cs_n got=%b bad=%b exp=110", rs_cs, rs_cs_bad); end
        checks++; if (rs_rx !== 8'h3C) begin failures++; $display("FAIL t1_rx_data got=%h exp=3c", rs_rx); end
        checks++; if (rs_mosi_bad !== 1'b0) begin failures++; $display("FAIL t1_mosi_on_fall got=%b exp=0", rs_mosi_bad); end
        checks++; if (rs_sclk_end !== 1'b0) begin failures++; $display("FAIL t1_sclk_rest got=%b exp=0", rs_sclk_end); end
        checks++; if (rs_pulse_ok !== 1'b1) begin failures++; $display("FAIL t1_pulse_idle got=%b exp=1", rs_pulse_ok); end
    endtask

    task automatic test_back_to_back;
        int         n, acc, rxc, gap, phase;
        int         acc_n [2];
        logic       flag;
        logic [2:0] c, cs_a, cs_b;
        logic [7:0] rx_a, rx_b;
        @(negedge clk);
        tx_data = 8'h01; tx_slave = 2'd1; tx_valid[0] = 1'b1;
        n = 0; acc = 0; rxc = 0; gap = 0; phase = 0; flag = 1'b0;
        cs_a = 3'b111; cs_b = 3'b111; rx_a = '0; rx_b = '0;
        acc_n[0] = -1; acc_n[1] = -1;
        while (rxc < 2 && n < 200) begin
            if (tx_ready[0] && tx_valid[0] && acc < 2) begin
                acc_n[acc] = n;
                acc++;
                flag = 1'b1;
            end
            @(negedge clk);
            n++;
            if (flag) begin
                flag = 1'b0;
                if (acc == 1) begin tx_data = 8'h02; tx_slave = 2'd0; end
                else tx_valid[0] = 1'b0;
            end
            c = get_cs(0);
            if (c != 3'b111) begin
                if (phase == 0) begin cs_a = c; phase = 1; end
                else if (phase == 2) begin cs_b = c; phase = 3; end
            end else if (phase == 1) begin
                phase = 2; gap = 1;
            end else if (phase == 2) begin
                gap++;
            end
            if (rx_valid[0]) begin
                if (rxc == 0) rx_a = rx_data0; else rx_b = rx_data0;
                rxc++;
            end
        end
        tx_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rxc !== 2) begin failures++; $display("FAIL t2_rx_pulses got=%0d exp=2", rxc); end
        checks++; if (cs_a !== 3'b101) begin failures++; $display("FAIL t2_cs_first got=%b exp=101", cs_a); end
        checks++; if (cs_b !== 3'b110) begin failures++; $display("FAIL t2_cs_second got=%b exp=110", cs_b); end
        checks++; if (gap < 1) begin failures++; $display("FAIL t2_cs_gap got=%0d exp>=1", gap); end
        checks++; if (acc_n[1] - acc_n[0] !== 37) begin failures++; $display("FAIL t2_accept_spacing got=%0d exp=37", acc_n[1] - acc_n[0]); end
        checks++; if (rx_a !== 8'h3C) begin failures++; $display("FAIL t2_rx_first got=%h exp=3c", rx_a); end
        checks++; if (rx_b !== 8'h3C) begin failures++; $display("FAIL t2_rx_second got=%h exp=3c", rx_b); end
    endtask

    task automatic test_mode3;
        @(negedge clk);
        checks++; if (sclk[1] !== 1'b1) begin failures++; $display("FAIL t3_sclk_idle got=%b exp=1", sclk[1]); end
        run_xfer(1, 8'hC3, 2'd0);
        checks++; if (rs_lat !== 36) begin failures++; $display("FAIL t3_latency got=%0d exp=36", rs_lat); end
        checks++; if (rs_mosi !== 8'hC3) begin failures++; $display("FAIL t3_mosi_bits got=%h exp=c3", rs_mosi); end
        checks++; if (rs_mosi_bad !== 1'b0) begin failures++; $display("FAIL t3_mosi_on_fall got=%b exp=0", rs_mosi_bad); end
        checks++; if (rs_rises !== 8) begin failures++; $display("FAIL t3_sclk_pulses got=%0d exp=8", rs_rises); end
        checks++; if (rs_cs !== 3'b110) begin failures++; $display("FAIL t3_cs_n got=%b exp=110", rs_cs); end
        checks++; if (rs_rx !== 8'h3C) begin failures++; $display("FAIL t3_rx_data got=%h exp=3c", rs_rx); end
        checks++; if (rs_sclk_end !== 1'b1) begin failures++; $display("FAIL t3_sclk_rest got=%b exp=1", rs_sclk_end); end
    endtask

    task automatic test_reset_mid;
        int   n, edges, seen;
        logic ps;
        @(negedge clk);
        tx_data = 8'hA5; tx_slave = 2'd0; tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        n = 0; edges = 0; ps = sclk[0];
        while (edges < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (sclk[0] != ps) edges++;
            ps = sclk[0];
        end
        checks++; if (edges !== 4) begin failures++; $display("FAIL t4_edges got=%0d exp=4", edges); end
        rst_n = 1'b0;
        #1;
        checks++; if (cs_n0 !== 2'b11) begin failures++; $display("FAIL t4_cs_n got=%b exp=11", cs_n0); end
        checks++; if (sclk[0] !== 1'b0) begin failures++; $display("FAIL t4_sclk got=%b exp=0", sclk[0]); end
        checks++; if (tx_ready[0] !== 1'b1) begin failures++; $display("FAIL t4_tx_ready got=%b exp=1", tx_ready[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rx_valid[0]) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL t4_no_rx_valid got=%0d exp=0", seen); end
        run_xfer(0, 8'hA5, 2'd0);
        checks++; if (rs_lat !== 36) begin failures++; $display("FAIL t4_next_latency got=%0d exp=36", rs_lat); end
        checks++; if (rs_mosi !== 8'hA5) begin failures++; $display("FAIL t4_next_mosi got=%h exp=a5", rs_mosi); end
        checks++; if (rs_rx !== 8'h3C) begin failures++; $display("FAIL t4_next_rx got=%h exp=3c", rs_rx); end
    endtask

    task automatic test_bad_slave;
        run_xfer(2, 8'h55, 2'd3);
        checks++; if (rs_cs_any !== 1'b0) begin failures++; $display("FAIL t5_cs_never got=%b exp=0", rs_cs_any); end
        checks++; if (rs_timeout !== 1'b0) begin failures++; $display("FAIL t5_timeout got=%b exp=0", rs_timeout); end
        checks++; if (rs_lat !== 36) begin failures++; $display("FAIL t5_latency got=%0d exp=36", rs_lat); end
        checks++; if (rs_mosi !== 8'h55) begin failures++; $display("FAIL t5_mosi_bits got=%h exp=55", rs_mosi); end
        run_xfer(2, 8'h0F, 2'd2);
        checks++; if (rs_cs !== 3'b011 || rs_cs_bad) begin failures++; $display("FAIL t5_cs_slave2 got=%b bad=%b exp=011", rs_cs, rs_cs_bad); end
        checks++; if (rs_rx !== 8'hFF) begin failures++; $display("FAIL t5_rx_data got=%h exp=ff", rs_rx); end
    endtask

`ifdef SPI_MASTER_LOOPBACK_EN
    task automatic test_loopback;
        loopback = 1'b1;
        run_xfer(0, 8'h96, 2'd0);
        loopback = 1'b0;
        checks++; if (rs_rx !== 8'h96) begin failures++; $display("FAIL t6_rx_data got=%h exp=96", rs_rx); end
        checks++; if (rs_cs_any !== 1'b0) begin failures++; $display("FAIL t6_cs_never got=%b exp=0", rs_cs_any); end
        checks++; if (rs_lat !== 36) begin failures++; $display("FAIL t6_latency got=%0d exp=36", rs_lat); end
    endtask
`endif

    initial begin
`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = 1'b0;
`endif
        test_reset();
        test_basic();
        test_back_to_back();
        test_mode3();
        test_reset_mid();
        test_bad_slave();
`ifdef SPI_MASTER_LOOPBACK_EN
        test_loopback();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
